// File: rtl/pc_next_ctrl_pkg.sv
// Shared pipeline definitions for next-PC control: trap FSM encoding, cause codes
// and the default trap vector.
package pc_next_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_VECTOR = 2'd2
  } pc_state_e;

  localparam logic [1:0] CAUSE_IRQ     = 2'd0;
  localparam logic [1:0] CAUSE_SYSCALL = 2'd1;
  localparam logic [1:0] CAUSE_UNIMPL  = 2'd2;
  localparam logic [1:0] CAUSE_OVF     = 2'd3;

  localparam logic [31:0] DEFAULT_VECTOR_PC = 32'h0000_0008;

  // The cause register holds the 2-bit code in bits [3:2].
  function automatic logic [31:0] make_cause(input logic [1:0] code);
    return {28'b0, code, 2'b00};
  endfunction

endpackage

// File: rtl/pc_src_mux.sv
// 4:1 selector for the normal next-PC target; targets pass through untouched.
module pc_src_mux (
  input  logic [1:0]  i_sel,
  input  logic [31:0] i_pc4,
  input  logic [31:0] i_bpc,
  input  logic [31:0] i_rpc,
  input  logic [31:0] i_jpc,
  output logic [31:0] o_pc
);

  always_comb begin
    o_pc = i_pc4;
    case (i_sel)
      2'd0: o_pc = i_pc4;
      2'd1: o_pc = i_bpc;
      2'd2: o_pc = i_rpc;
      2'd3: o_pc = i_jpc;
      default: o_pc = i_pc4;
    endcase
  end

endmodule

// File: rtl/pc_next_ctrl.sv
// Next-PC controller: normal target selection plus trap entry (with FPU drain),
// trap vectoring and return-from-trap.
module pc_next_ctrl
  import pc_next_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] VECTOR_PC = DEFAULT_VECTOR_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc4,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] rpc,
  input  logic [1:0]  pcsrc,
  input  logic        stall,
  input  logic [31:0] pc_d,
  input  logic        irq,
  input  logic        exc,
  input  logic [1:0]  exc_code,
  input  logic        eret,
  input  logic        fpu_busy,
  output logic [31:0] npc,
  output logic        wpc,
  output logic        flush,
  output logic [31:0] epc,
  output logic [31:0] cause,
  output logic        in_trap,
  output logic [1:0]  dbg_state
);

  pc_state_e   r_state;
  pc_state_e   w_next_state;
  logic [31:0] r_epc;
  logic [31:0] r_cause;
  logic        r_in_trap;
  logic [31:0] w_mux_pc;
  logic        w_take_irq;
  logic        w_take;
  logic        w_do_eret;
  logic [1:0]  w_trap_code;

  pc_src_mux u_pc_src_mux (
    .i_sel (pcsrc),
    .i_pc4 (pc4),
    .i_bpc (bpc),
    .i_rpc (rpc),
    .i_jpc (jpc),
    .o_pc  (w_mux_pc)
  );

  // irq is level-sensitive: it is simply not taken while masked or stalled,
  // so it is naturally re-evaluated every cycle.
  assign w_take_irq  = irq & ~r_in_trap & ~stall;
  assign w_take      = exc | w_take_irq;
  assign w_do_eret   = eret & r_in_trap & ~stall;
  assign w_trap_code = exc ? exc_code : CAUSE_IRQ;

  always_comb begin
    npc          = w_mux_pc;
    wpc          = 1'b0;
    flush        = 1'b1;
    w_next_state = r_state;
    if (rst) begin
      npc          = RESET_PC;
      wpc          = 1'b1;
      w_next_state = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_take) begin
            w_next_state = fpu_busy ? ST_DRAIN : ST_VECTOR;
          end else if (w_do_eret) begin
            npc = r_epc;
            wpc = 1'b1;
          end else begin
            wpc   = ~stall;
            flush = 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!fpu_busy) w_next_state = ST_VECTOR;
        end
        ST_VECTOR: begin
          npc          = VECTOR_PC;
          wpc          = 1'b1;
          w_next_state = ST_RUN;
        end
        default: w_next_state = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_epc     <= 32'h0;
      r_cause   <= 32'h0;
      r_in_trap <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_RUN && w_take) begin
        r_epc     <= pc_d;
        r_cause   <= make_cause(w_trap_code);
        r_in_trap <= 1'b1;
      end else if (r_state == ST_RUN && w_do_eret) begin
        r_in_trap <= 1'b0;
      end
    end
  end

  assign epc       = r_epc;
  assign cause     = r_cause;
  assign in_trap   = r_in_trap;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pc_next_ctrl.sv
// Directed bench for pc_next_ctrl: the driver pushes the hand-computed response
// for each cycle and a negedge monitor pops and compares it.
module tb_pc_next_ctrl;

  typedef struct packed {
    logic        chk_npc;
    logic [31:0] npc;
    logic        wpc;
    logic        flush;
    logic [31:0] epc;
    logic [31:0] cause;
    logic        in_trap;
    logic [1:0]  st;
  } exp_t;

  localparam logic [1:0] R = 2'd0, D = 2'd1, V = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc4, bpc, jpc, rpc, pc_d;
  logic [1:0]  pcsrc, exc_code;
  logic        stall, irq, exc, eret, fpu_busy;
  logic [31:0] npc, epc, cause;
  logic        wpc, flush, in_trap;
  logic [1:0]  dbg_state;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  pc_next_ctrl dut (
    .clk(clk), .rst(rst), .pc4(pc4), .bpc(bpc), .jpc(jpc), .rpc(rpc),
    .pcsrc(pcsrc), .stall(stall), .pc_d(pc_d), .irq(irq), .exc(exc),
    .exc_code(exc_code), .eret(eret), .fpu_busy(fpu_busy),
    .npc(npc), .wpc(wpc), .flush(flush), .epc(epc), .cause(cause),
    .in_trap(in_trap), .dbg_state(dbg_state)
  );

  function automatic exp_t mk(input logic c, input logic [31:0] n, input logic w,
                              input logic f, input logic [31:0] e, input logic [31:0] ca,
                              input logic t, input logic [1:0] s);
    exp_t x;
    x = '{chk_npc: c, npc: n, wpc: w, flush: f, epc: e, cause: ca, in_trap: t, st: s};
    return x;
  endfunction

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] src, input logic st,
                       input logic [31:0] pcd, input logic i, input logic e,
                       input logic [1:0] code, input logic er, input logic fb,
                       input exp_t x);
    rst = r; pcsrc = src; stall = st; pc_d = pcd; irq = i; exc = e;
    exc_code = code; eret = er; fpu_busy = fb;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented cycle has one expected entry.
  int cyc = 0;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t x;
      x = exp_q.pop_front();
      cyc++;
      if (x.chk_npc) chk("npc", cyc, npc, x.npc);
      chk("wpc", cyc, {31'b0, wpc}, {31'b0, x.wpc});
      chk("flush", cyc, {31'b0, flush}, {31'b0, x.flush});
      chk("epc", cyc, epc, x.epc);
      chk("cause", cyc, cause, x.cause);
      chk("in_trap", cyc, {31'b0, in_trap}, {31'b0, x.in_trap});
      chk("state", cyc, {30'b0, dbg_state}, {30'b0, x.st});
    end
  end

  initial begin
    rst = 1'b1; pcsrc = 2'd0; stall = 1'b0; pc_d = 32'h0; irq = 1'b0; exc = 1'b0;
    exc_code = 2'd0; eret = 1'b0; fpu_busy = 1'b0;
    pc4 = 32'h1004; bpc = 32'h40; rpc = 32'h2000; jpc = 32'h3000;
    repeat (2) @(posedge clk);
    #1;
    //     rst src stl pc_d      irq exc cd eret fb   expected
    drive(1, 0, 0, 32'h0,   0, 0, 0, 0, 0, mk(1, 32'h0,    1, 1, 32'h0,   32'h0, 0, R));
    drive(0, 0, 0, 32'h0,   0, 0, 0, 0, 0, mk(1, 32'h1004, 1, 0, 32'h0,   32'h0, 0, R));
    drive(0, 1, 0, 32'h0,   0, 0, 0, 0, 0, mk(1, 32'h40,   1, 0, 32'h0,   32'h0, 0, R));
    drive(0, 1, 1, 32'h0,   0, 0, 0, 0, 0, mk(1, 32'h40,   0, 0, 32'h0,   32'h0, 0, R));
    drive(0, 2, 0, 32'h0,   0, 0, 0, 0, 0, mk(1, 32'h2000, 1, 0, 32'h0,   32'h0, 0, R));
    drive(0, 3, 0, 32'h0,   0, 0, 0, 0, 0, mk(1, 32'h3000, 1, 0, 32'h0,   32'h0, 0, R));
    drive(0, 0, 0, 32'h0,   0, 0, 0, 1, 0, mk(1, 32'h1004, 1, 0, 32'h0,   32'h0, 0, R));
    drive(0, 0, 1, 32'h0,   1, 0, 0, 0, 0, mk(1, 32'h1004, 0, 0, 32'h0,   32'h0, 0, R));
    drive(0, 0, 0, 32'h100, 1, 0, 0, 0, 0, mk(0, 32'h0,    0, 1, 32'h0,   32'h0, 0, R));
    drive(0, 0, 1, 32'h0,   0, 0, 0, 0, 0, mk(1, 32'h8,    1, 1, 32'h100, 32'h0, 1, V));
    drive(0, 0, 0, 32'h0,   1, 0, 0, 0, 0, mk(1, 32'h1004, 1, 0, 32'h100, 32'h0, 1, R));
    drive(0, 0, 0, 32'h0,   1, 0, 0, 1, 0, mk(1, 32'h100,  1, 1, 32'h100, 32'h0, 1, R));
    drive(0, 0, 0, 32'h200, 1, 0, 0, 0, 0, mk(0, 32'h0,    0, 1, 32'h100, 32'h0, 0, R));
    drive(0, 0, 0, 32'h0,   0, 0, 0, 0, 0, mk(1, 32'h8,    1, 1, 32'h200, 32'h0, 1, V));
    drive(0, 0, 0, 32'h300, 1, 1, 3, 0, 1, mk(0, 32'h0,    0, 1, 32'h200, 32'h0, 1, R));
    drive(0, 0, 0, 32'h0,   1, 0, 0, 1, 1, mk(0, 32'h0,    0, 1, 32'h300, 32'hC, 1, D));
    drive(0, 0, 0, 32'h0,   1, 0, 0, 0, 1, mk(0, 32'h0,    0, 1, 32'h300, 32'hC, 1, D));
    drive(0, 0, 0, 32'h0,   1, 0, 0, 0, 0, mk(0, 32'h0,    0, 1, 32'h300, 32'hC, 1, D));
    drive(0, 0, 0, 32'h0,   0, 0, 0, 0, 0, mk(1, 32'h8,    1, 1, 32'h300, 32'hC, 1, V));
    drive(0, 0, 1, 32'h0,   0, 0, 0, 1, 0, mk(1, 32'h1004, 0, 0, 32'h300, 32'hC, 1, R));
    drive(0, 0, 0, 32'h0,   0, 0, 0, 1, 0, mk(1, 32'h300,  1, 1, 32'h300, 32'hC, 1, R));
    drive(0, 0, 0, 32'h400, 0, 1, 1, 0, 1, mk(0, 32'h0,    0, 1, 32'h300, 32'hC, 0, R));
    drive(0, 0, 0, 32'h0,   0, 0, 0, 0, 1, mk(0, 32'h0,    0, 1, 32'h400, 32'h4, 1, D));
    drive(1, 0, 0, 32'h0,   0, 0, 0, 0, 1, mk(1, 32'h0,    1, 1, 32'h400, 32'h4, 1, D));
    drive(0, 1, 0, 32'h0,   0, 0, 0, 0, 0, mk(1, 32'h40,   1, 0, 32'h0,   32'h0, 0, R));
    drive(0, 0, 1, 32'h500, 0, 1, 2, 0, 0, mk(0, 32'h0,    0, 1, 32'h0,   32'h0, 0, R));
    drive(1, 0, 0, 32'h0,   0, 0, 0, 0, 0, mk(1, 32'h0,    1, 1, 32'h500, 32'h8, 1, V));
    drive(0, 3, 0, 32'h0,   0, 0, 0, 0, 0, mk(1, 32'h3000, 1, 0, 32'h0,   32'h0, 0, R));
    @(posedge clk);
    #1;
    chk("queue_drained", cyc, exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_next_ctrl.md
PC_NEXT_CTRL -- requirements
Module: pc_next_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value driven after reset.
REQ-002 SHALL have parameter VECTOR_PC, default 32'h0000_0008, trap handler entry address.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have ports pc4, bpc, jpc, rpc, each input, 32: sequential, branch, jump and register-jump targets.
REQ-006 SHALL have port pcsrc, input, 2, normal target select: 0 pc4, 1 bpc, 2 rpc, 3 jpc.
REQ-007 SHALL have port stall, input, 1, pipeline hazard/FPU stall from the hazard unit.
REQ-008 SHALL have port pc_d, input, 32, PC of the instruction in ID.
REQ-009 SHALL have ports irq (input, 1, level interrupt request), exc (input, 1, synchronous exception of the ID instruction), exc_code (input, 2) and eret (input, 1, return-from-trap in ID).
REQ-010 SHALL have port fpu_busy, input, 1, FPU has uncommitted operations in flight.
REQ-011 SHALL have ports npc (output, 32) and wpc (output, 1): D and enable feeding the 32-bit PC register.
REQ-012 SHALL have ports flush (output, 1, kill IF/ID), epc (output, 32), cause (output, 32) and in_trap (output, 1).

Function
REQ-013 SHALL implement states RUN, DRAIN, VECTOR.
REQ-014 In RUN with no trap or eret, npc SHALL be selected by pcsrc, wpc = ~stall, flush = 0.
REQ-015 In RUN, a trap SHALL be taken when exc = 1, or when irq = 1 and in_trap = 0 and stall = 0.
REQ-016 Priority SHALL be exc > irq > eret > stall > normal; a concurrently pending irq stays pending, being level-sensitive.
REQ-017 On trap take: epc <= pc_d; cause <= {28'b0, code, 2'b00}, code = exc_code for exc, 2'b00 for irq; in_trap <= 1; flush = 1 that cycle.
REQ-018 On trap take, the next state SHALL be DRAIN if fpu_busy = 1, else VECTOR.
REQ-019 In DRAIN: wpc = 0, flush = 1; leave for VECTOR on the first cycle fpu_busy = 0; irq/exc/eret are ignored.
REQ-020 In VECTOR (exactly one cycle): npc = VECTOR_PC, wpc = 1 regardless of stall, flush = 1; next state RUN.
REQ-021 Trap-to-vector latency SHALL be 1 cycle (take -> VECTOR) plus the number of DRAIN cycles.
REQ-022 eret in RUN with in_trap = 1 and stall = 0: npc = epc, wpc = 1, flush = 1, in_trap <= 0 next edge.
REQ-023 eret with in_trap = 0 SHALL be treated as a no-op (normal sequencing).
REQ-024 eret and irq in the same cycle with in_trap = 1: eret SHALL execute; irq is re-evaluated the following cycle.
REQ-025 Nested exc while in_trap = 1 SHALL overwrite epc/cause and re-vector.
REQ-026 All targets SHALL pass unmodified; no alignment checks, no arithmetic.

Reset
REQ-027 While rst = 1: state = RUN, npc = RESET_PC, wpc = 1, flush = 1, epc = 0, cause = 0, in_trap = 0.
REQ-028 rst asserted in DRAIN or VECTOR SHALL abandon the trap with no residue on the next edge.
REQ-029 The first cycle after rst falls SHALL follow REQ-014.

Structure
REQ-030 State encoding, cause code constants (IRQ 0, SYSCALL 1, UNIMPL 2, OVF 3) and VECTOR_PC default SHALL live in the shared pipeline package.
REQ-031 SHALL contain one sub-module, pc_src_mux (4:1 32-bit target mux); the FSM and epc/cause registers are inline.

Verification
REQ-032 pcsrc = 1, bpc = 32'h40, stall = 0 -> npc = 32'h40, wpc = 1; stall = 1 -> wpc = 0.
REQ-033 irq = 1, pc_d = 32'h100, fpu_busy = 0 -> epc = 32'h100, cause = 0, flush, npc = 32'h8 one cycle later.
REQ-034 exc = 1, exc_code = 3 with irq = 1, fpu_busy high 3 cycles -> cause = 32'hC, 3 DRAIN cycles with wpc = 0, then VECTOR.
REQ-035 eret in handler, epc = 32'h100 -> npc = 32'h100, in_trap = 0; simultaneous irq taken the next cycle.
REQ-036 rst pulsed during DRAIN -> npc = RESET_PC, in_trap = 0, state RUN, no VECTOR cycle issued.
